// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file feeding a single-stage ALU with a one-entry
// registered output. Operands are read combinationally on accept. The result,
// flags and optional write-back all land on the same rising edge.
module reg_alu_pipe #(
    parameter int DATA_W  = 32,
    parameter int NUM_W   = 5,
    parameter int ZERO_R0 = 1,
    parameter int SAT_EN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [NUM_W-1:0]  rd_num_a,
    input  logic [NUM_W-1:0]  rd_num_b,
    input  logic [NUM_W-1:0]  dst_num,
    input  logic              wb_en,
    input  logic              ext_wr_en,
    input  logic [NUM_W-1:0]  ext_wr_num,
    input  logic [DATA_W-1:0] ext_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              out_zero,
    output logic [15:0]       op_count
);

    localparam int NUM_REGS = 2 ** NUM_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [DATA_W-1:0] reg_file [NUM_REGS];

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_carry_reg;
    logic              out_zero_reg;
    logic [15:0]       op_count_reg;

    logic              accept;
    logic              drain;

    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] result_next;
    logic              carry_next;
    logic              zero_next;

    // The output stage can take a new result when empty or when it is being drained.
    assign in_ready = !out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_reg & out_ready;

    // Reads see the file as it was before this edge's writes (no write-through).
    assign operand_a = reg_file[rd_num_a];
    assign operand_b = reg_file[rd_num_b];

    assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};

    // ALU: bit DATA_W of the widened add/sub is the carry/borrow; saturation clamps unsigned.
    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        case (op)
            OP_ADD: begin
                carry_next  = sum_ext[DATA_W];
                result_next = (SAT_EN != 0 && sum_ext[DATA_W]) ? '1 : sum_ext[DATA_W-1:0];
            end
            OP_SUB: begin
                carry_next  = diff_ext[DATA_W];
                result_next = (SAT_EN != 0 && diff_ext[DATA_W]) ? '0 : diff_ext[DATA_W-1:0];
            end
            OP_AND: result_next = operand_a & operand_b;
            OP_OR:  result_next = operand_a | operand_b;
            default: result_next = '0;
        endcase
        zero_next = (result_next == '0);
    end

    // Register file: one storage word per register; write-back beats an external write.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] value_reg;

        if (ZERO_R0 != 0 && gi == 0) begin : g_hard_zero
            assign value_reg = '0;
        end else begin : g_writable
            logic wb_hit;
            logic ext_hit;

            assign wb_hit  = accept & wb_en & (dst_num == NUM_W'(gi));
            assign ext_hit = ext_wr_en & (ext_wr_num == NUM_W'(gi));

            // Update this register on write-back or external write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (wb_hit) begin
                    value_reg <= result_next;
                end else if (ext_hit) begin
                    value_reg <= ext_wr_data;
                end
            end
        end

        assign reg_file[gi] = value_reg;
    end

    // Output stage: load on accept, empty on drain without accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_carry_reg <= 1'b0;
            out_zero_reg  <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= result_next;
            out_carry_reg <= carry_next;
            out_zero_reg  <= zero_next;
        end else if (drain) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Count accepted operations, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (accept) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_carry = out_carry_reg;
    assign out_zero  = out_zero_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: two 8-bit instances (wrapping and saturating) share
// all inputs. Expected results are queued on accept and checked on output.
module tb_reg_alu_pipe;

    localparam int DW = 8;
    localparam int NW = 5;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

    typedef struct packed {
        logic [7:0] d0;
        logic       c0;
        logic       z0;
        logic [7:0] d1;
        logic       c1;
        logic       z1;
    } exp_t;

    typedef struct packed {
        logic [1:0] n_ext;
        logic [4:0] en0;
        logic [7:0] ev0;
        logic [4:0] en1;
        logic [7:0] ev1;
        logic [1:0] op;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] dst;
        logic       wb;
        exp_t       e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    op;
    logic [NW-1:0] rd_num_a, rd_num_b, dst_num, ext_wr_num;
    logic          wb_en, ext_wr_en, out_ready;
    logic [DW-1:0] ext_wr_data;

    logic          ir0, ov0, oc0, oz0, ir1, ov1, oc1, oz1;
    logic [DW-1:0] od0, od1;
    logic [15:0]   cnt0, cnt1;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[15];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_res   = 0;

    always #5 clk = ~clk;

    reg_alu_pipe #(.DATA_W(DW), .NUM_W(NW), .ZERO_R0(1), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .op(op),
        .rd_num_a(rd_num_a), .rd_num_b(rd_num_b), .dst_num(dst_num), .wb_en(wb_en),
        .ext_wr_en(ext_wr_en), .ext_wr_num(ext_wr_num), .ext_wr_data(ext_wr_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_carry(oc0),
        .out_zero(oz0), .op_count(cnt0)
    );

    reg_alu_pipe #(.DATA_W(DW), .NUM_W(NW), .ZERO_R0(1), .SAT_EN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .op(op),
        .rd_num_a(rd_num_a), .rd_num_b(rd_num_b), .dst_num(dst_num), .wb_en(wb_en),
        .ext_wr_en(ext_wr_en), .ext_wr_num(ext_wr_num), .ext_wr_data(ext_wr_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_carry(oc1),
        .out_zero(oz1), .op_count(cnt1)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic ext_write(input logic [4:0] num, input logic [7:0] data);
        ext_wr_en   = 1'b1;
        ext_wr_num  = num;
        ext_wr_data = data;
        @(posedge clk); #1;
        ext_wr_en   = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic w);
        op       = o;
        rd_num_a = a;
        rd_num_b = b;
        dst_num  = d;
        wb_en    = w;
        in_valid = 1'b1;
    endtask

    // Present a request (optionally with a same-edge external write) until accepted.
    task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic w, input exp_t e,
                         input logic xe, input logic [4:0] xn, input logic [7:0] xd);
        bit done = 1'b0;
        drive_req(o, a, b, d, w);
        ext_wr_en   = xe;
        ext_wr_num  = xn;
        ext_wr_data = xd;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (ir0) begin
                sb_q.push_back(e);
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        wb_en     = 1'b0;
        ext_wr_en = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    // Scoreboard: every result leaving the output stage is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && ov0 && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got data %02h, expected no result", od0);
            end else begin
                mon_e = sb_q.pop_front();
                n_res++;
                chk("wrap_data",  16'(od0), 16'(mon_e.d0));
                chk("wrap_carry", 16'(oc0), 16'(mon_e.c0));
                chk("wrap_zero",  16'(oz0), 16'(mon_e.z0));
                chk("sat_valid",  16'(ov1), 16'd1);
                chk("sat_data",   16'(od1), 16'(mon_e.d1));
                chk("sat_carry",  16'(oc1), 16'(mon_e.c1));
                chk("sat_zero",   16'(oz1), 16'(mon_e.z1));
                $display("[TB] result %0d: wrap %02h c%0d z%0d | sat %02h c%0d z%0d", n_res,
                         od0, oc0, oz0, od1, oc1, oz1);
            end
        end
    end

    initial begin
        //          n     en0    ev0    en1    ev1    op   ra     rb     dst    wb    d0/c0/z0 d1/c1/z1
        vecs[0]  = '{2'd2, 5'd1, 8'h05, 5'd2, 8'h03, ADD, 5'd1, 5'd2, 5'd4, 1'b1, '{8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0}};
        vecs[1]  = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, AND, 5'd4, 5'd4, 5'd0, 1'b0, '{8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0}};
        vecs[2]  = '{2'd2, 5'd1, 8'hF0, 5'd2, 8'h20, ADD, 5'd1, 5'd2, 5'd0, 1'b0, '{8'h10, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0}};
        vecs[3]  = '{2'd1, 5'd2, 8'h03, 5'd0, 8'h00, SUB, 5'd2, 5'd2, 5'd0, 1'b0, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}};
        vecs[4]  = '{2'd2, 5'd1, 8'h03, 5'd2, 8'h05, SUB, 5'd1, 5'd2, 5'd0, 1'b0, '{8'hFE, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1}};
        vecs[5]  = '{2'd2, 5'd5, 8'hA0, 5'd6, 8'h0C, OR,  5'd5, 5'd6, 5'd0, 1'b0, '{8'hAC, 1'b0, 1'b0, 8'hAC, 1'b0, 1'b0}};
        vecs[6]  = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, AND, 5'd5, 5'd6, 5'd0, 1'b0, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}};
        vecs[7]  = '{2'd2, 5'd1, 8'h80, 5'd2, 8'h80, ADD, 5'd1, 5'd2, 5'd0, 1'b0, '{8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0}};
        vecs[8]  = '{2'd2, 5'd0, 8'h09, 5'd1, 8'h07, ADD, 5'd0, 5'd1, 5'd0, 1'b0, '{8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0}};
        vecs[9]  = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, ADD, 5'd1, 5'd1, 5'd0, 1'b1, '{8'h0E, 1'b0, 1'b0, 8'h0E, 1'b0, 1'b0}};
        vecs[10] = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, OR,  5'd0, 5'd0, 5'd0, 1'b0, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}};
        vecs[11] = '{2'd2, 5'd1, 8'hFF, 5'd2, 8'h00, SUB, 5'd1, 5'd2, 5'd0, 1'b0, '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0}};
        vecs[12] = '{2'd1, 5'd3, 8'h09, 5'd0, 8'h00, OR,  5'd3, 5'd3, 5'd0, 1'b0, '{8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0}};
        vecs[13] = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, ADD, 5'd4, 5'd1, 5'd7, 1'b1, '{8'h07, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0}};
        vecs[14] = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, OR,  5'd7, 5'd7, 5'd0, 1'b0, '{8'h07, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0}};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = ADD;
        rd_num_a    = '0;
        rd_num_b    = '0;
        dst_num     = '0;
        wb_en       = 1'b0;
        ext_wr_en   = 1'b0;
        ext_wr_num  = '0;
        ext_wr_data = '0;
        out_ready   = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  16'(ir0),  16'd1);
        chk("rst_out_valid", 16'(ov0),  16'd0);
        chk("rst_out_data",  16'(od0),  16'd0);
        chk("rst_out_carry", 16'(oc0),  16'd0);
        chk("rst_out_zero",  16'(oz0),  16'd0);
        chk("rst_op_count",  cnt0,      16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven operations.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].n_ext > 2'd0) ext_write(vecs[i].en0, vecs[i].ev0);
            if (vecs[i].n_ext > 2'd1) ext_write(vecs[i].en1, vecs[i].ev1);
            issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].dst, vecs[i].wb, vecs[i].e,
                  1'b0, 5'd0, 8'h00);
        end

        // Write-back and external write to r3 on the same edge: write-back wins.
        ext_write(5'd1, 8'h03);
        ext_write(5'd2, 8'h04);
        issue(ADD, 5'd1, 5'd2, 5'd3, 1'b1, '{8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0}, 1'b1, 5'd3, 8'h09);
        issue(OR,  5'd3, 5'd3, 5'd0, 1'b0, '{8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0}, 1'b0, 5'd0, 8'h00);

        // A read on the edge of an external write to the same register sees the old value.
        ext_write(5'd1, 8'h10);
        issue(ADD, 5'd1, 5'd0, 5'd0, 1'b0, '{8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0}, 1'b1, 5'd1, 8'h20);
        issue(OR,  5'd1, 5'd1, 5'd0, 1'b0, '{8'h20, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0}, 1'b0, 5'd0, 8'h00);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained_1", 16'(sb_q.size()), 16'd0);
        chk("op_count_1",      cnt0, 16'(n_acc));

        // Reset while a result is pending: everything clears at once.
        out_ready = 1'b0;
        ext_write(5'd1, 8'h55);
        issue(OR, 5'd1, 5'd1, 5'd0, 1'b0, '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0}, 1'b0, 5'd0, 8'h00);
        @(negedge clk);
        chk("pending_valid", 16'(ov0), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 16'(ov0),  16'd0);
        chk("midrst_out_data",  16'(od0),  16'd0);
        chk("midrst_op_count",  cnt0,      16'd0);
        chk("midrst_in_ready",  16'(ir0),  16'd1);
        sb_q.delete();
        n_acc = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-pressure: first result holds, second request waits, then goes the cycle out_ready rises.
        ext_write(5'd1, 8'h11);
        ext_write(5'd2, 8'h22);
        issue(ADD, 5'd1, 5'd2, 5'd0, 1'b0, '{8'h33, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0}, 1'b0, 5'd0, 8'h00);
        drive_req(SUB, 5'd2, 5'd1, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 16'(ir0), 16'd0);
            chk("bp_valid",    16'(ov0), 16'd1);
            chk("bp_hold",     16'(od0), 16'h33);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 16'(ir0), 16'd1);
        sb_q.push_back('{8'h11, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0});
        n_acc++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_after", 16'(ov0), 16'd1);
        chk("bp_op_count",    cnt0,     16'd2);

        // Registers written before the reset read back as zero.
        @(posedge clk); #1;
        issue(OR, 5'd4, 5'd7, 5'd0, 1'b0, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}, 1'b0, 5'd0, 8'h00);
        issue(OR, 5'd3, 5'd5, 5'd0, 1'b0, '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}, 1'b0, 5'd0, 8'h00);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained_2", 16'(sb_q.size()), 16'd0);
        chk("op_count_wrap",   cnt0, 16'(n_acc));
        chk("op_count_sat",    cnt1, 16'(n_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
